seq_alu: RTL
============

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 32, is the datapath width; it SHALL be at least 8 and a power of two.
REQ-002 Parameter SHW, default $clog2(WIDTH), is the shift-amount width.
REQ-003 Port clk, input, 1: the single clock; all state SHALL update on the rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port in_valid input 1, in_ready output 1: operation request handshake.
REQ-006 Ports opcode input 4, cond input 4, set_flags input 1: operation, condition code and flag-update enable.
REQ-007 Ports op_a and op_b, input, WIDTH each: signed operands.
REQ-008 Port imm, input, 16: immediate for MOVI.
REQ-009 Ports sh_ctrl input 2, sh_amt input SHW: operand-B shift control (00 none, 01 logical right, 10 logical left, 11 rotate right).
REQ-010 Port out_valid output 1, out_ready input 1: result handshake.
REQ-011 Ports result output WIDTH, wb_en output 1, flags output 4 ({N,Z,C,V}), busy output 1.

Function
REQ-012 A request SHALL be accepted only on a cycle where in_valid and in_ready are both 1; in_ready = (state==IDLE).
REQ-013 The FSM SHALL have three states: IDLE; MUL (multiply iterating); HOLD (result presented, waiting for out_ready).
REQ-014 Opcode encoding SHALL be: 0 ADD, 1 SUB, 2 MUL, 3 OR, 4 AND, 5 XOR, 6 MOVI, 7 MOV, B CMP, D LDR-pass, F NOP; every other code SHALL be STR-pass (result=op_a).
REQ-015 Shift control SHALL apply to op_b for ADD, SUB, MUL, OR, AND and XOR only; CMP SHALL use the unshifted op_b.
REQ-016 cond codes 0-8 SHALL mean always, EQ, GT, LT, GE, LE (signed) and HI, LO, HS (unsigned), comparing op_a against unshifted op_b; codes 9-F SHALL mean never.
REQ-017 The condition SHALL be evaluated at acceptance. If it is false, the FSM SHALL go to HOLD with wb_en=0, result=0 and the flags register unchanged.
REQ-018 Single-cycle ops SHALL go IDLE->HOLD, so out_valid rises the cycle after acceptance (latency 1).
REQ-019 MUL SHALL be an iterative shift-add: IDLE->MUL, WIDTH iterations, then HOLD. Latency SHALL be WIDTH+1 cycles, and result SHALL be the low WIDTH bits of the product.
REQ-020 NOP SHALL be accepted but SHALL NOT produce out_valid; the state SHALL stay IDLE.
REQ-021 MOVI SHALL zero-extend imm to WIDTH. CMP SHALL set wb_en=0, compute op_a-op_b and always update the flags.
REQ-022 Flag rules: N = result MSB; Z = (result==0); C = carry out for ADD, no-borrow for SUB/CMP, 0 for other ops; V = signed overflow for ADD/SUB/CMP, 0 for other ops.
REQ-023 The flags register SHALL update on HOLD entry only when the condition is met and (set_flags or CMP) holds.
REQ-024 HOLD->IDLE SHALL occur on out_valid && out_ready. result, wb_en and flags SHALL stay stable while out_valid=1 and out_ready=0.
REQ-025 busy SHALL be 1 in states MUL and HOLD.

Reset
REQ-026 reset SHALL force IDLE, out_valid=0, result=0, wb_en=0, flags=0 and the multiply counter=0, including when asserted mid-MUL or in HOLD. An in-flight operation SHALL be discarded with no output.

Configuration
REQ-027 With macro SEQ_ALU_MUL_EN defined, MUL SHALL behave as in REQ-019.
REQ-028 Without SEQ_ALU_MUL_EN, MUL SHALL complete in 1 cycle with result=0 and wb_en=0, the flags SHALL be unchanged, and no multiplier logic SHALL be synthesised.

Structure
REQ-029 A shared package seq_alu_pkg SHALL hold the opcode, cond and sh_ctrl enums, the state enum, and the flag bit-index constants.
REQ-030 The shifter/rotator SHALL be one sub-module, seq_alu_shift (WIDTH-parametrised, combinational).

Verification
REQ-031 ADD, WIDTH=32, a=7FFFFFFF, b=1, set_flags=1 -> out_valid after 1 cycle, result=80000000, flags N=1 Z=0 C=0 V=1.
REQ-032 MUL, a=-3, b=5 -> out_valid exactly 33 cycles after acceptance, result=FFFFFFF1; with SEQ_ALU_MUL_EN undefined -> 1 cycle, wb_en=0.
REQ-033 SUB with cond=LT, a=5, b=9 -> wb_en=1, result=FFFFFFFC; same request with cond=GT -> wb_en=0, flags unchanged.
REQ-034 ADD with a=0, b=1, sh_ctrl=10, sh_amt=4 -> result=10. The same operation with WIDTH=16 -> result=0010.
REQ-035 out_ready held at 0 for 5 cycles in HOLD -> result stable and in_ready=0 throughout; out_ready=1 -> IDLE next cycle.
REQ-036 reset asserted at MUL iteration 10 -> IDLE next cycle, out_valid never asserted, flags=0.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// Shared types for the sequential ALU: opcodes, condition codes, shift controls,
// FSM states and the bit positions of the {N,Z,C,V} flags.
package seq_alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_MUL  = 4'h2,
    OP_OR   = 4'h3,
    OP_AND  = 4'h4,
    OP_XOR  = 4'h5,
    OP_MOVI = 4'h6,
    OP_MOV  = 4'h7,
    OP_STR  = 4'h8,
    OP_CMP  = 4'hB,
    OP_LDR  = 4'hD,
    OP_NOP  = 4'hF
  } opcode_e;

  typedef enum logic [3:0] {
    CC_AL = 4'h0,
    CC_EQ = 4'h1,
    CC_GT = 4'h2,
    CC_LT = 4'h3,
    CC_GE = 4'h4,
    CC_LE = 4'h5,
    CC_HI = 4'h6,
    CC_LO = 4'h7,
    CC_HS = 4'h8,
    CC_NV = 4'h9
  } cond_e;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSR  = 2'b01,
    SH_LSL  = 2'b10,
    SH_ROR  = 2'b11
  } sh_ctrl_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_HOLD = 2'b10
  } state_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/seq_alu_shift.sv
// Combinational operand-B shifter: pass, logical right, logical left or rotate right.
module seq_alu_shift import seq_alu_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] din,
  input  logic [1:0]       sh_ctrl,
  input  logic [SHW-1:0]   sh_amt,
  output logic [WIDTH-1:0] dout
);

  // Rotation is the low half of the doubled word shifted right.
  always_comb begin
    dout = din;
    case (sh_ctrl)
      SH_LSR:  dout = din >> sh_amt;
      SH_LSL:  dout = din << sh_amt;
      SH_ROR:  dout = WIDTH'({din, din} >> sh_amt);
      default: dout = din;
    endcase
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with conditional execution, flags and an optional iterative
// shift-add multiplier enabled by defining SEQ_ALU_MUL_EN.
module seq_alu import seq_alu_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [3:0]       cond,
  input  logic             set_flags,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [15:0]      imm,
  input  logic [1:0]       sh_ctrl,
  input  logic [SHW-1:0]   sh_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             wb_en,
  output logic [3:0]       flags,
  output logic             busy
);

  state_e           state_q, state_d;
  logic             accept, cond_ok, is_sub, alu_c, alu_v, alu_wb;
  logic [WIDTH-1:0] b_sh, b_add, alu_res;
  logic [WIDTH:0]   sum;
  logic [3:0]       alu_flags;

`ifdef SEQ_ALU_MUL_EN
  logic [WIDTH-1:0] mul_acc, mul_mcand, mul_mplier, mul_sum;
  logic [SHW-1:0]   mul_cnt;
  logic             mul_setf, mul_last;

  assign mul_sum  = mul_acc + (mul_mplier[0] ? mul_mcand : '0);
  assign mul_last = (mul_cnt == SHW'(WIDTH - 1));
`endif

  seq_alu_shift #(.WIDTH(WIDTH), .SHW(SHW)) u_shift (
    .din    (op_b),
    .sh_ctrl(sh_ctrl),
    .sh_amt (sh_amt),
    .dout   (b_sh)
  );

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_HOLD);
  assign busy      = (state_q != ST_IDLE);
  assign accept    = in_valid && in_ready;

  always_comb begin
    cond_ok = 1'b0;
    case (cond)
      CC_AL:   cond_ok = 1'b1;
      CC_EQ:   cond_ok = (op_a == op_b);
      CC_GT:   cond_ok = ($signed(op_a) >  $signed(op_b));
      CC_LT:   cond_ok = ($signed(op_a) <  $signed(op_b));
      CC_GE:   cond_ok = ($signed(op_a) >= $signed(op_b));
      CC_LE:   cond_ok = ($signed(op_a) <= $signed(op_b));
      CC_HI:   cond_ok = (op_a >  op_b);
      CC_LO:   cond_ok = (op_a <  op_b);
      CC_HS:   cond_ok = (op_a >= op_b);
      default: cond_ok = 1'b0;
    endcase
  end

  // One adder serves ADD, SUB and CMP; subtraction is a + ~b + 1 so the
  // carry out is directly the no-borrow flag.
  always_comb begin
    is_sub  = (opcode == OP_SUB) || (opcode == OP_CMP);
    b_add   = (opcode == OP_CMP) ? op_b : b_sh;
    if (is_sub)
      b_add = ~b_add;
    sum     = {1'b0, op_a} + {1'b0, b_add} + {{WIDTH{1'b0}}, is_sub};
    alu_res = op_a;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_wb  = 1'b1;
    case (opcode)
      OP_ADD, OP_SUB, OP_CMP: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (op_a[WIDTH-1] == b_add[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
        alu_wb  = (opcode != OP_CMP);
      end
      OP_OR:   alu_res = op_a | b_sh;
      OP_AND:  alu_res = op_a & b_sh;
      OP_XOR:  alu_res = op_a ^ b_sh;
      OP_MOVI: alu_res = WIDTH'(imm);
      OP_MOV:  alu_res = op_b;
      OP_LDR:  alu_res = op_a;
      default: begin
        alu_res = op_a;
        alu_wb  = 1'b0;
      end
    endcase
    alu_flags         = '0;
    alu_flags[FLAG_N] = alu_res[WIDTH-1];
    alu_flags[FLAG_Z] = (alu_res == '0);
    alu_flags[FLAG_C] = alu_c;
    alu_flags[FLAG_V] = alu_v;
  end

  always_ff @(posedge clk) begin
    if (reset)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && (opcode != OP_NOP)) begin
`ifdef SEQ_ALU_MUL_EN
          state_d = ((opcode == OP_MUL) && cond_ok) ? ST_MUL : ST_HOLD;
`else
          state_d = ST_HOLD;
`endif
        end
      end
`ifdef SEQ_ALU_MUL_EN
      ST_MUL:  if (mul_last) state_d = ST_HOLD;
`endif
      ST_HOLD: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Result, wb_en and flags only move on HOLD entry, so they stay frozen while HOLD waits.
  always_ff @(posedge clk) begin
    if (reset) begin
      result <= '0;
      wb_en  <= 1'b0;
      flags  <= '0;
`ifdef SEQ_ALU_MUL_EN
      mul_acc    <= '0;
      mul_mcand  <= '0;
      mul_mplier <= '0;
      mul_cnt    <= '0;
      mul_setf   <= 1'b0;
`endif
    end else if ((state_q == ST_IDLE) && accept && (opcode != OP_NOP)) begin
      if (!cond_ok) begin
        result <= '0;
        wb_en  <= 1'b0;
      end else if (opcode == OP_MUL) begin
`ifdef SEQ_ALU_MUL_EN
        mul_acc    <= '0;
        mul_mcand  <= op_a;
        mul_mplier <= b_sh;
        mul_cnt    <= '0;
        mul_setf   <= set_flags;
`else
        result <= '0;
        wb_en  <= 1'b0;
`endif
      end else begin
        result <= alu_res;
        wb_en  <= alu_wb;
        if (set_flags || (opcode == OP_CMP))
          flags <= alu_flags;
      end
    end
`ifdef SEQ_ALU_MUL_EN
    else if (state_q == ST_MUL) begin
      mul_acc    <= mul_sum;
      mul_mcand  <= mul_mcand << 1;
      mul_mplier <= mul_mplier >> 1;
      mul_cnt    <= mul_cnt + SHW'(1);
      if (mul_last) begin
        mul_cnt <= '0;
        result  <= mul_sum;
        wb_en   <= 1'b1;
        if (mul_setf)
          flags <= {mul_sum[WIDTH-1], (mul_sum == '0), 2'b00};
      end
    end
`endif
  end

endmodule
